data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have parameter MEMORY_DEPTH, default 64, number of words.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h10010000, byte address of word 0.
REQ-004 SHALL have parameter WAIT_STATES, default 2, extra access cycles, range 0..15.
REQ-005 SHALL have port clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port Req_i, input, 1, access request.
REQ-008 SHALL have port Write_Enable_i, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port Size_i, input, 2, access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-010 SHALL have port Unsigned_i, input, 1, load extension: 1 = zero-extend, 0 = sign-extend.
REQ-011 SHALL have port Address_i, input, DATA_WIDTH, byte address.
REQ-012 SHALL have port Write_Data_i, input, DATA_WIDTH, store data, right-aligned.
REQ-013 SHALL have port Busy_o, output, 1, high whenever the FSM is not in IDLE.
REQ-014 SHALL have port Ready_o, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port Read_Data_o, output, DATA_WIDTH, registered load result.
REQ-016 SHALL have port Fault_o, output, 1, access error, valid while Ready_o is high.

Function
REQ-017 SHALL use FSM states IDLE, WAIT and DONE.
REQ-018 SHALL, in IDLE with Req_i=1, latch address, data, size, write enable and Unsigned_i, load the counter with WAIT_STATES and go to WAIT.
REQ-019 SHALL ignore Req_i in WAIT and DONE.
REQ-020 SHALL, in WAIT, decrement the counter when it is nonzero, otherwise perform the access and go to DONE.
REQ-021 SHALL hold Ready_o high only in DONE, for exactly one cycle, then return to IDLE.
REQ-022 SHALL therefore assert Ready_o in the cycle after WAIT_STATES+1 edges following the accepting edge.
REQ-023 SHALL accept the next request no earlier than the IDLE cycle after DONE, with no back-to-back pipelining.
REQ-024 SHALL compute the word index as (addr - BASE_ADDR) >> 2 truncated to clog2(MEMORY_DEPTH) bits, and the byte lane as addr[1:0].
REQ-025 SHALL, on a store, modify only the addressed lanes: byte writes Write_Data_i[7:0] to lane addr[1:0], half writes [15:0] to lanes addr[1]*2..+1, word writes all lanes.
REQ-026 SHALL, on a load, extract the addressed byte or half and extend it per Unsigned_i.
REQ-027 SHALL register the load result into Read_Data_o at the DONE-entry edge and hold it until the next load completes.
REQ-028 SHALL leave Read_Data_o unchanged on a store.

Reset
REQ-029 SHALL force, while reset=0 and irrespective of clk, state IDLE, counter 0, Busy_o 0, Ready_o 0, Read_Data_o 0 and Fault_o 0.
REQ-030 SHALL discard an access in flight when reset asserts before DONE, leaving memory unwritten.
REQ-031 SHALL not reset memory contents.

Configuration
REQ-032 SHALL, with DATA_MEM_FAULT_EN defined, flag misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0) and out-of-range accesses (addr < BASE_ADDR or addr-BASE_ADDR >= 4*MEMORY_DEPTH).
REQ-033 SHALL, on a flagged access, suppress the write, load Read_Data_o with 0 and assert Fault_o together with Ready_o.
REQ-034 SHALL, without DATA_MEM_FAULT_EN, tie Fault_o to 0, wrap the index modulo MEMORY_DEPTH and ignore misaligned low bits (half uses addr[1] only, word ignores addr[1:0]).

Structure
REQ-035 SHALL place the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the FSM state type in package data_mem_pkg.
REQ-036 SHALL implement lane merge on store and lane extraction with extension on load in a combinational sub-module data_mem_lane.

Verification
REQ-037 SHALL cover: WAIT_STATES=2, store word 0x10010004 <= 0xDEADBEEF, then load word 0x10010004 -> Ready_o 3 cycles after each accept, Read_Data_o=0xDEADBEEF.
REQ-038 SHALL cover: store byte 0x10010005 <= 0x80, then load byte signed -> 0xFFFFFF80, unsigned -> 0x00000080, and word -> 0xDEAD80EF.
REQ-039 SHALL cover: store half 0x10010006 <= 0x1234, then load word 0x10010004 -> 0x123480EF.
REQ-040 SHALL cover: with DATA_MEM_FAULT_EN, load word 0x10010002 and store 0x10010100 -> Fault_o=1 with Ready_o, Read_Data_o=0, memory unchanged.
REQ-041 SHALL cover: reset pulsed low during WAIT of a store -> outputs immediately 0, later load of that address returns the old value.
REQ-042 SHALL cover: Req_i held high continuously -> one accept per WAIT_STATES+3 cycles, Busy_o low for exactly one cycle between accesses.

Source files
------------

// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_pkg
//  Purpose  : Access-size encodings and FSM state type for data_mem_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/data_mem_lane.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_lane
//  Purpose  : Store lane merge and load lane extraction with sign/zero extend.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_lane
    import data_mem_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Half accesses select by lane_i[1]; lane_i[0] is expected to be 0 here.
    assign w_byte = old_word_i[{lane_i, 3'b000} +: 8];
    assign w_half = old_word_i[{lane_i[1], 4'b0000} +: 16];

    always_comb begin
        merged_o = old_word_i;
        load_o   = old_word_i;
        case (size_i)
            SIZE_BYTE: begin
                merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
                load_o = {{24{~unsigned_i & w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
                load_o = {{16{~unsigned_i & w_half[15]}}, w_half};
            end
            default: begin
                merged_o = wdata_i;
                load_o   = old_word_i;
            end
        endcase
    end

endmodule : data_mem_lane
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_ctrl
//  Purpose  : Wait-stated byte/half/word data memory. Define DATA_MEM_FAULT_EN
//             to flag misaligned and out-of-range accesses on Fault_o.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h10010000,
    parameter int                    WAIT_STATES  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Req_i,
    input  logic                  Write_Enable_i,
    input  logic [1:0]            Size_i,
    input  logic                  Unsigned_i,
    input  logic [DATA_WIDTH-1:0] Address_i,
    input  logic [DATA_WIDTH-1:0] Write_Data_i,
    output logic                  Busy_o,
    output logic                  Ready_o,
    output logic [DATA_WIDTH-1:0] Read_Data_o,
    output logic                  Fault_o
);

    localparam int IDX_W = $clog2(MEMORY_DEPTH);

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [1:0]              size_q;
    logic                    we_q;
    logic                    uns_q;
    logic                    busy_q;
    logic                    ready_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    fault_q;

    logic [DATA_WIDTH-1:0]   mem_q [MEMORY_DEPTH];

    logic [DATA_WIDTH-1:0]   w_offset;
    logic [IDX_W-1:0]        w_index;
    logic [1:0]              w_lane;
    logic [DATA_WIDTH-1:0]   w_old;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic [DATA_WIDTH-1:0]   w_load;
    logic                    w_fault;
    logic                    w_access;
    logic                    w_unused_bits;

    assign w_offset = addr_q - BASE_ADDR;
    assign w_index  = w_offset[IDX_W+1:2];
    assign w_old    = mem_q[w_index];
    assign w_access = (state_q == WAIT) && (cnt_q == 4'd0);

    // Misaligned low bits are dropped so the lane unit only sees legal lanes.
    always_comb begin
        w_lane = 2'b00;
        case (size_q)
            SIZE_BYTE: w_lane = addr_q[1:0];
            SIZE_HALF: w_lane = {addr_q[1], 1'b0};
            default:   w_lane = 2'b00;
        endcase
    end

`ifdef DATA_MEM_FAULT_EN
    logic w_misalign;
    logic w_range;

    assign w_misalign = ((size_q == SIZE_HALF) && addr_q[0]) ||
                        ((size_q[1] == 1'b1) && (addr_q[1:0] != 2'b00));
    assign w_range    = (addr_q < BASE_ADDR) ||
                        (w_offset >= DATA_WIDTH'(4 * MEMORY_DEPTH));
    assign w_fault    = w_misalign | w_range;
    assign w_unused_bits = ^w_offset[1:0];
`else
    assign w_fault       = 1'b0;
    assign w_unused_bits = ^{w_offset[DATA_WIDTH-1:IDX_W+2], w_offset[1:0]};
`endif

    data_mem_lane u_lane (
        .old_word_i (w_old),
        .wdata_i    (wdata_q),
        .size_i     (size_q),
        .lane_i     (w_lane),
        .unsigned_i (uns_q),
        .merged_o   (w_merged),
        .load_o     (w_load)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SIZE_BYTE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    fault_q <= 1'b0;
                    if (Req_i) begin
                        addr_q  <= Address_i;
                        wdata_q <= Write_Data_i;
                        size_q  <= Size_i;
                        we_q    <= Write_Enable_i;
                        uns_q   <= Unsigned_i;
                        cnt_q   <= 4'(WAIT_STATES);
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        ready_q <= 1'b1;
                        fault_q <= w_fault;
                        state_q <= DONE;
                        if (w_fault) begin
                            rdata_q <= '0;
                        end else if (!we_q) begin
                            rdata_q <= w_load;
                        end
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    fault_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    fault_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Contents survive reset; an aborted access never reaches this write.
    always_ff @(posedge clk) begin
        if (w_access && we_q && !w_fault) begin
            mem_q[w_index] <= w_merged;
        end
    end

    assign Busy_o      = busy_q;
    assign Ready_o     = ready_q;
    assign Read_Data_o = rdata_q;
    assign Fault_o     = fault_q;

endmodule : data_mem_ctrl
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_ctrl
//  Purpose  : Directed self-checking bench for data_mem_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    localparam int WS = 2;

    logic        clk;
    logic        reset;
    logic        Req_i;
    logic        Write_Enable_i;
    logic [1:0]  Size_i;
    logic        Unsigned_i;
    logic [31:0] Address_i;
    logic [31:0] Write_Data_i;
    logic        Busy_o;
    logic        Ready_o;
    logic [31:0] Read_Data_o;
    logic        Fault_o;

    int          n_checks;
    int          n_errors;
    logic [31:0] rd;
    logic        flt;
    logic [9:0]  busy_obs, busy_exp, rdy_obs, rdy_exp;

    data_mem_ctrl #(
        .DATA_WIDTH   (32),
        .MEMORY_DEPTH (64),
        .BASE_ADDR    (32'h10010000),
        .WAIT_STATES  (WS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .Req_i          (Req_i),
        .Write_Enable_i (Write_Enable_i),
        .Size_i         (Size_i),
        .Unsigned_i     (Unsigned_i),
        .Address_i      (Address_i),
        .Write_Data_i   (Write_Data_i),
        .Busy_o         (Busy_o),
        .Ready_o        (Ready_o),
        .Read_Data_o    (Read_Data_o),
        .Fault_o        (Fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete access: checks acceptance, latency and the single Ready pulse.
    task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input string tag,
                          output logic [31:0] rdata, output logic fault);
        int cyc;
        cyc = 0;
        @(negedge clk);
        Req_i = 1'b1; Write_Enable_i = we; Size_i = sz; Unsigned_i = uns;
        Address_i = a; Write_Data_i = wd;
        @(posedge clk);
        #1;
        Req_i = 1'b0;
        check({tag, "_busy"}, {31'b0, Busy_o}, 32'd1);
        while (cyc < 20 && Ready_o !== 1'b1) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, cyc, WS + 2);
        rdata = Read_Data_o;
        fault = Fault_o;
        @(negedge clk);
        check({tag, "_pulse"}, {30'b0, Ready_o, Busy_o}, 32'd0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset = 1'b0; Req_i = 1'b0; Write_Enable_i = 1'b0; Size_i = 2'b00;
        Unsigned_i = 1'b0; Address_i = '0; Write_Data_i = '0;

        @(negedge clk);
        check("rst_out", {Read_Data_o[30:0], Busy_o}, 32'd0);
        check("rst_flags", {30'b0, Ready_o, Fault_o}, 32'd0);
        reset = 1'b1;

        access(1'b1, 2'b10, 1'b0, 32'h10010004, 32'hDEADBEEF, "st_w", rd, flt);
        check("st_w_rd", rd, 32'h0);
        check("st_w_flt", {31'b0, flt}, 32'd0);
        access(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0, "ld_w", rd, flt);
        check("ld_w_rd", rd, 32'hDEADBEEF);

        access(1'b1, 2'b00, 1'b0, 32'h10010005, 32'hAAAAAA80, "st_b", rd, flt);
        check("st_b_hold", rd, 32'hDEADBEEF);
        access(1'b0, 2'b00, 1'b0, 32'h10010005, 32'h0, "ld_bs", rd, flt);
        check("ld_bs_rd", rd, 32'hFFFFFF80);
        access(1'b0, 2'b00, 1'b1, 32'h10010005, 32'h0, "ld_bu", rd, flt);
        check("ld_bu_rd", rd, 32'h00000080);
        access(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0, "ld_w2", rd, flt);
        check("ld_w2_rd", rd, 32'hDEAD80EF);

        access(1'b1, 2'b01, 1'b0, 32'h10010006, 32'h55551234, "st_h", rd, flt);
        access(1'b0, 2'b11, 1'b0, 32'h10010004, 32'h0, "ld_w3", rd, flt);
        check("ld_w3_rd", rd, 32'h123480EF);
        access(1'b0, 2'b01, 1'b0, 32'h10010006, 32'h0, "ld_hs", rd, flt);
        check("ld_hs_rd", rd, 32'h00001234);

        access(1'b1, 2'b10, 1'b0, 32'h10010008, 32'h80017F00, "st_w8", rd, flt);
        access(1'b0, 2'b01, 1'b0, 32'h1001000A, 32'h0, "ld_hs8", rd, flt);
        check("ld_hs8_rd", rd, 32'hFFFF8001);
        access(1'b0, 2'b01, 1'b1, 32'h10010008, 32'h0, "ld_hu8", rd, flt);
        check("ld_hu8_rd", rd, 32'h00007F00);
        access(1'b0, 2'b00, 1'b0, 32'h10010009, 32'h0, "ld_bs9", rd, flt);
        check("ld_bs9_rd", rd, 32'h0000007F);
        check("ld_bs9_flt", {31'b0, flt}, 32'd0);

        access(1'b1, 2'b10, 1'b0, 32'h10010000, 32'h11223344, "st_w0", rd, flt);
`ifdef DATA_MEM_FAULT_EN
        access(1'b0, 2'b10, 1'b0, 32'h10010002, 32'h0, "f_mis", rd, flt);
        check("f_mis_flt", {31'b0, flt}, 32'd1);
        check("f_mis_rd", rd, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0, "f_re", rd, flt);
        check("f_re_rd", rd, 32'h123480EF);
        access(1'b1, 2'b10, 1'b0, 32'h10010100, 32'hCAFEF00D, "f_oor", rd, flt);
        check("f_oor_flt", {31'b0, flt}, 32'd1);
        check("f_oor_rd", rd, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h1000FFFC, 32'h0, "f_low", rd, flt);
        check("f_low_flt", {31'b0, flt}, 32'd1);
        access(1'b0, 2'b10, 1'b0, 32'h10010000, 32'h0, "f_keep", rd, flt);
        check("f_keep_rd", rd, 32'h11223344);
        check("f_keep_flt", {31'b0, flt}, 32'd0);
`else
        access(1'b1, 2'b10, 1'b0, 32'h10010100, 32'hCAFEF00D, "wrap_st", rd, flt);
        check("wrap_st_flt", {31'b0, flt}, 32'd0);
        access(1'b0, 2'b10, 1'b0, 32'h10010000, 32'h0, "wrap_ld", rd, flt);
        check("wrap_ld_rd", rd, 32'hCAFEF00D);
        access(1'b0, 2'b10, 1'b0, 32'h10010002, 32'h0, "mis_w", rd, flt);
        check("mis_w_rd", rd, 32'hCAFEF00D);
        access(1'b0, 2'b01, 1'b1, 32'h10010007, 32'h0, "mis_h", rd, flt);
        check("mis_h_rd", rd, 32'h00001234);
`endif

        // Abort a store while it is still waiting.
        @(negedge clk);
        Req_i = 1'b1; Write_Enable_i = 1'b1; Size_i = 2'b10; Unsigned_i = 1'b0;
        Address_i = 32'h10010004; Write_Data_i = 32'h0BADF00D;
        @(posedge clk);
        #1;
        Req_i = 1'b0;
        @(negedge clk);
        check("abort_pre", {31'b0, Busy_o}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_out", {Read_Data_o[30:0], Busy_o}, 32'd0);
        check("abort_flags", {30'b0, Ready_o, Fault_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        access(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0, "abort_ld", rd, flt);
        check("abort_ld_rd", rd, 32'h123480EF);

        // Continuous request: one accept per WS+3 cycles.
        @(negedge clk);
        Req_i = 1'b1; Write_Enable_i = 1'b0; Size_i = 2'b10; Address_i = 32'h10010004;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            busy_obs[i-1] = Busy_o;
            rdy_obs[i-1]  = Ready_o;
            busy_exp[i-1] = (i % (WS + 3)) != 0;
            rdy_exp[i-1]  = (i % (WS + 3)) == (WS + 2);
        end
        Req_i = 1'b0;
        check("hold_busy", {22'b0, busy_obs}, {22'b0, busy_exp});
        check("hold_ready", {22'b0, rdy_obs}, {22'b0, rdy_exp});
        @(negedge clk);
        check("hold_idle", {31'b0, Busy_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_data_mem_ctrl
`default_nettype wire
